// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Holds the funct3 encodings for loads and stores and the state encoding of
// the access FSM. It also provides the helpers that turn an access size and
// byte offset into byte enables and lane-replicated store data.
package rv32_mem_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Byte enables for an access of the given size code (f3[1:0]) at byte
    // offset off. Size code 11 never reaches the bus because it is illegal.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store source across all lanes so that the byte enables
    // alone pick the bytes that get written.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wdata;
        case (size)
            2'b00:   wdata = {4{data[7:0]}};
            2'b01:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data memory port bundle between the load/store unit and the memory.
// Signals:
//   mem_req    request from the unit, held until granted
//   mem_we     1 = write, 0 = read
//   mem_addr   word-aligned byte address
//   mem_wdata  lane-replicated store data
//   mem_be     byte enables
//   mem_gnt    memory accepted the request this cycle
//   mem_rvalid read data valid
//   mem_rdata  read data
// The master modport is the load/store unit; the slave modport is the memory.
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational store-lane alignment and legality check.
// Ports:
//   we        1 = store request, 0 = load request
//   f3        funct3 of the access
//   off       byte offset addr[1:0]
//   st_data   store source (rs2)
//   mem_be    byte enables for the access
//   mem_wdata lane-replicated store data
//   legal     funct3 is valid for this direction and the address is aligned
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        legal
);

    logic f3_ok;
    logic align_ok;

    // Stores only have signed-style encodings; loads also accept the
    // unsigned byte/half variants. Alignment depends only on the size code.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b0;
        if (we) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b0;
        endcase
        legal     = f3_ok & align_ok;
        mem_be    = lane_be(f3[1:0], off);
        mem_wdata = lane_wdata(f3[1:0], st_data);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Accepts a load or store from the execute stage, checks it, runs the
// request/grant/response handshake with the data memory and stalls the
// pipeline while the access is in flight. Load data is returned shifted down
// to bit 0; the writeback stage does the final masking and extension.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   d_r_en, d_w_en  load / store request
//   f3              funct3 of the access
//   addr            effective byte address
//   st_data         store source
//   stall           pipeline hold
//   d_out           load data shifted to bit 0
//   d_out_valid     one-cycle pulse when an access completes
//   misalign_err    one-cycle pulse for a misaligned or illegal request
//   bus_err         one-cycle pulse when a load times out
//   mem             data memory port (master side)
module mem_access_unit
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_r_en,
    input  logic            d_w_en,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] st_data,
    output logic            stall,
    output logic [XLEN-1:0] d_out,
    output logic            d_out_valid,
    output logic            misalign_err,
    output logic            bus_err,
    mem_access_unit_if.master mem
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;

    logic            req;
    logic            both_req;
    logic            lane_legal;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new;
    logic            mem_req_c;

    assign req      = d_r_en | d_w_en;
    assign both_req = d_r_en & d_w_en;

    mem_lane_align u_lane_align (
        .we        (d_w_en),
        .f3        (f3),
        .off       (addr[1:0]),
        .st_data   (st_data),
        .mem_be    (be_new),
        .mem_wdata (wdata_new),
        .legal     (lane_legal)
    );

    // Next-state and output logic of the access FSM. Address, data and
    // enables are captured once at acceptance so they stay stable through
    // ISSUE no matter what the execute stage does meanwhile.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;
        mem_req_c   = 1'b0;
        d_out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (lane_legal && !both_req) begin
                        stall   = 1'b1;
                        off_d   = addr[1:0];
                        we_d    = d_w_en;
                        addr_d  = {addr[XLEN-1:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        state_d = ST_ISSUE;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                stall     = 1'b1;
                mem_req_c = 1'b1;
                if (mem.mem_gnt) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // rvalid is tested first so a response on the final cycle
                // still completes the load without a bus error.
                if (mem.mem_rvalid) begin
                    dout_d  = mem.mem_rdata >> {off_q, 3'b000};
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    dout_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                d_out_valid = 1'b1;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            cnt_q      <= 8'd0;
            dout_q     <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // A completing store shows 0 on d_out; the last load result is kept in
    // dout_q and reappears afterwards.
    assign d_out        = (state_q == ST_DONE && we_q) ? '0 : dout_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized loads and
// stores, each checked against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_r_en;
    logic        d_w_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        stall;
    logic [31:0] d_out;
    logic        d_out_valid;
    logic        misalign_err;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;
    int          writeCount = 0;
    logic [31:0] modelDout = 32'h0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_r_en       (d_r_en),
        .d_w_en       (d_w_en),
        .f3           (f3),
        .addr         (addr),
        .st_data      (st_data),
        .stall        (stall),
        .d_out        (d_out),
        .d_out_valid  (d_out_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    // Count granted writes seen on the memory port
    always @(posedge clk) begin
        if (!rst && bus.mem_req && bus.mem_gnt && bus.mem_we) writeCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int accessSize(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit isLegal(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a);
        int sz;
        sz = accessSize(f);
        if (ld == st) return 0;
        if (sz == 0) return 0;
        if (st && f[2]) return 0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] expectedBe(input logic [2:0] f, input logic [31:0] a);
        int be;
        be = ((1 << accessSize(f)) - 1) << (a % 4);
        return be[3:0];
    endfunction

    function automatic logic [31:0] expectedWdata(input logic [2:0] f, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        sz = accessSize(f);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_stall"}, stall, 0);
        checkOutput({tag, "_valid"}, d_out_valid, 0);
        checkOutput({tag, "_misalign"}, misalign_err, 0);
        checkOutput({tag, "_buserr"}, bus_err, 0);
        checkOutput({tag, "_req"}, bus.mem_req, 0);
        checkOutput({tag, "_we"}, bus.mem_we, 0);
        checkOutput({tag, "_dout"}, d_out, 0);
        checkOutput({tag, "_addr"}, bus.mem_addr, 0);
        checkOutput({tag, "_wdata"}, bus.mem_wdata, 0);
        checkOutput({tag, "_be"}, bus.mem_be, 0);
    endtask

    // One complete transaction, starting just after a rising edge in IDLE.
    // gntDelay: ISSUE cycles before the grant; rvDelay: WAIT cycles before
    // rvalid (>= TIMEOUT means no response).
    task automatic applyStimulus(input string name, input bit ld, input bit st, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] sd, input int gntDelay,
                                 input int rvDelay, input logic [31:0] rdata);
        bit legal;
        bit timedOut;
        int wcStart;
        legal    = isLegal(ld, st, f, a);
        timedOut = 0;
        wcStart  = writeCount;

        d_r_en = ld; d_w_en = st; f3 = f; addr = a; st_data = sd;
        @(negedge clk);
        checkOutput({name, "_accept_stall"}, stall, legal);
        checkOutput({name, "_accept_req"}, bus.mem_req, 0);
        @(posedge clk); #1;
        d_r_en = 0; d_w_en = 0; f3 = 3'($urandom); addr = $urandom; st_data = $urandom;

        if (!legal) begin
            @(negedge clk);
            checkOutput({name, "_misalign"}, misalign_err, 1);
            checkOutput({name, "_bad_req"}, bus.mem_req, 0);
            checkOutput({name, "_bad_stall"}, stall, 0);
            @(posedge clk); #1;
            checkOutput({name, "_bad_writes"}, writeCount - wcStart, 0);
            return;
        end

        for (int k = 0; k <= gntDelay; k++) begin
            bus.mem_gnt = (k == gntDelay); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            @(negedge clk);
            checkOutput({name, "_issue_req"}, bus.mem_req, 1);
            checkOutput({name, "_issue_stall"}, stall, 1);
            checkOutput({name, "_issue_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
            checkOutput({name, "_issue_be"}, bus.mem_be, expectedBe(f, a));
            checkOutput({name, "_issue_we"}, bus.mem_we, st);
            if (st) checkOutput({name, "_issue_wdata"}, bus.mem_wdata, expectedWdata(f, sd));
            @(posedge clk); #1;
        end
        bus.mem_gnt = 0;

        if (ld) begin
            for (int w = 0; w < TIMEOUT; w++) begin
                bus.mem_rvalid = (w == rvDelay);
                bus.mem_rdata  = (w == rvDelay) ? rdata : $urandom;
                @(negedge clk);
                checkOutput({name, "_wait_stall"}, stall, 1);
                checkOutput({name, "_wait_req"}, bus.mem_req, 0);
                checkOutput({name, "_wait_valid"}, d_out_valid, 0);
                @(posedge clk); #1;
                if (w == rvDelay) break;
            end
            if (rvDelay >= TIMEOUT) begin
                timedOut  = 1;
                modelDout = 32'h0;
            end else begin
                modelDout = rdata >> (8 * (a % 4));
            end
        end

        // Completion cycle; stray responses here must be ignored
        bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
        @(negedge clk);
        checkOutput({name, "_done_valid"}, d_out_valid, 1);
        checkOutput({name, "_done_stall"}, stall, 0);
        checkOutput({name, "_done_req"}, bus.mem_req, 0);
        checkOutput({name, "_done_buserr"}, bus_err, timedOut);
        checkOutput({name, "_done_dout"}, d_out, st ? 32'h0 : modelDout);
        @(posedge clk); #1;

        // Late response after completion
        bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
        @(negedge clk);
        checkOutput({name, "_after_valid"}, d_out_valid, 0);
        checkOutput({name, "_after_buserr"}, bus_err, 0);
        checkOutput({name, "_after_dout"}, d_out, modelDout);
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        checkOutput({name, "_writes"}, writeCount - wcStart, st ? 1 : 0);
    endtask

    // Load accepted and granted, then reset in the middle of WAIT
    task automatic resetMidWait();
        d_r_en = 1; d_w_en = 0; f3 = 3'b010; addr = 32'h0000_5000;
        @(posedge clk); #1;
        d_r_en = 0;
        bus.mem_gnt = 1;
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        @(negedge clk);
        checkOutput("rstwait_stall", stall, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        modelDout = 32'h0;
        @(negedge clk);
        checkResetValues("rstwait");
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        @(negedge clk);
        checkOutput("rstwait_late_dout", d_out, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int r, sel;
        bit ld, st;
        rst = 1; d_r_en = 0; d_w_en = 0; f3 = 0; addr = 0; st_data = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk); #1;

        $display("[TB] directed cases");
        applyStimulus("sb",       0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 0);
        applyStimulus("lhu",      1, 0, 3'b101, 32'h0000_2002, 0, 0, 2, 32'h1234_ABCD);
        applyStimulus("lw_mis",   1, 0, 3'b010, 32'h0000_3001, 0, 0, 0, 0);
        applyStimulus("sh_mis",   0, 1, 3'b001, 32'h0000_3003, 32'h1111_2222, 0, 0, 0);
        applyStimulus("both",     1, 1, 3'b010, 32'h0000_3000, 32'h3333_4444, 0, 0, 0);
        applyStimulus("sbu_ill",  0, 1, 3'b100, 32'h0000_3000, 32'h5555_6666, 0, 0, 0);
        applyStimulus("lw_to",    1, 0, 3'b010, 32'h0000_3004, 0, 0, TIMEOUT + 4, 32'h7777_8888);
        applyStimulus("lw_edge",  1, 0, 3'b010, 32'h0000_3008, 0, 1, TIMEOUT - 1, 32'h8765_4321);
        applyStimulus("sw_slow",  0, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5, 0, 0);
        resetMidWait();
        applyStimulus("lb_after", 1, 0, 3'b000, 32'h0000_6001, 0, 0, 0, 32'h89AB_CDEF);

        $display("[TB] randomized cases");
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            ld  = (sel == 0) || (sel >= 5);
            st  = (sel <= 4);
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            r   = $urandom_range(0, 7);
            applyStimulus($sformatf("rnd%0d", n), ld, st, 3'($urandom), a, $urandom,
                          $urandom_range(0, 3),
                          (r == 0) ? TIMEOUT + 2 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3),
                          $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the execute stage and the data memory port. It is the producer side of the writeback stage's load path.
- Stores: aligns store data into byte lanes and generates byte enables.
- Loads: issues the read, then returns memory data shifted down to bit 0. The writeback stage then applies byte/half/word masking and sign/zero extension.
- Runs a request/grant/response handshake with the memory and stalls the pipeline while an access is in flight.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before a bus error is raised (range 2..255).
- XLEN, 32: data/address width; fixed at 32 for RV32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d_r_en  in  1  load request from the execute stage
- d_w_en  in  1  store request from the execute stage
- f3  in  3  funct3 of the load/store
- addr  in  32  effective byte address (ALU_out)
- st_data  in  32  store source (rs2)
- stall  out  1  pipeline hold
- d_out  out  32  load data, lane-shifted to bit 0
- d_out_valid  out  1  one-cycle pulse when an access completes
- misalign_err  out  1  one-cycle pulse: misaligned or illegal access
- bus_err  out  1  one-cycle pulse: load timed out
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address; {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE; stall, d_out_valid, misalign_err, bus_err, mem_req and mem_we all 0; d_out, mem_addr, mem_wdata 0; mem_be 4'b0000; timeout counter 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request (d_r_en=0, d_w_en=0): stay in IDLE.
- IDLE, request present: legality is checked combinationally in the same cycle.
  - Legal store f3: 000, 001, 010. Legal load f3: 000, 001, 010, 100, 101.
  - Halfword (f3[1:0]=01) requires addr[0]=0. Word requires addr[1:0]=00.
  - d_r_en and d_w_en both high is illegal.
- Illegal or misaligned request: misalign_err pulses on the next cycle; no memory request is made; stall stays 0; state stays IDLE.
- Legal request:
  - stall goes high combinationally in the same cycle.
  - Register: byte offset addr[1:0], f3, we, mem_addr, mem_wdata, mem_be.
  - Next state is ISSUE.
- Byte enables:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
  - Loads drive the same enable pattern.
- Store data lanes:
  - byte: {4{st_data[7:0]}}
  - half: {2{st_data[15:0]}}
  - word: st_data
- ISSUE: mem_req=1 and stall=1, with address/data/enables held stable until mem_gnt=1.
  - On grant of a store: go to DONE.
  - On grant of a load: go to WAIT, timeout counter cleared.
  - mem_req drops the cycle after grant.
- WAIT: stall=1 and the counter increments every cycle.
  - On mem_rvalid: register d_out = mem_rdata >> (8*off); go to DONE.
  - When the counter reaches TIMEOUT-1 without rvalid: d_out=0, bus_err pulses, go to DONE.
  - If mem_rvalid and the timeout coincide, rvalid wins: no bus_err.
- DONE (exactly one cycle): stall=0 and d_out_valid=1.
  - d_out_valid is 1 for both stores and loads; the store d_out value is don't-care but equals 0.
  - d_r_en/d_w_en are ignored this cycle because the pipeline is advancing.
  - Next state IDLE.
- d_out holds its value until the next load completes.
- mem_rvalid outside WAIT is ignored. mem_gnt outside ISSUE is ignored.
- Reset mid-operation: returns to IDLE in the next cycle and drops mem_req. Any late response is ignored.
- Back-to-back requests: best case is 1 idle cycle between accesses (IDLE→ISSUE→DONE→IDLE).
- Throughput:
  - Store with immediate grant: 3 cycles from acceptance to the DONE cycle inclusive.
  - Load with grant and rvalid on the following cycle: 4 cycles.

Decomposition:
- Shared package rv32_mem_pkg:
  - f3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding.
  - Lane/byte-enable generation function.
- Sub-module mem_lane_align (combinational) takes f3, off and st_data and produces mem_be, mem_wdata and the legal flag.
- The load-side shift stays inline in mem_access_unit.

Test Plan:
- SB, addr=0x1003, st_data=0xAABBCCDD, mem_gnt high on ISSUE → mem_addr=0x1000, mem_be=1000, mem_wdata=0xDDDDDDDD, mem_we=1; d_out_valid pulses 2 cycles after acceptance; stall low in the DONE cycle.
- LHU, addr=0x2002, mem_rdata=0x1234ABCD with rvalid 3 cycles after grant → d_out=0x00001234, d_out_valid one cycle after rvalid, stall high throughout WAIT.
- LW, addr=0x3001 → misalign_err pulse next cycle, mem_req never asserted, stall=0; same for SH at 0x3003 and for d_r_en=d_w_en=1.
- LW with TIMEOUT=16 and rvalid never asserted → bus_err after 16 WAIT cycles, d_out=0, state back to IDLE; a late rvalid afterwards does not change d_out.
- Grant delayed 5 cycles on SW 0x4000 data 0xCAFEF00D → mem_req, mem_addr, mem_wdata and mem_be=1111 stable for all 6 ISSUE cycles, exactly one write.
- rst asserted during WAIT → next cycle IDLE, mem_req=0, stall=0, all outputs at reset values; the following LB completes normally.
